// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: instruction kinds, forward-select constants
// and the per-stage scoreboard slot record.
package pipe_pkg;

  typedef enum logic [1:0] {
    KIND_ALU  = 2'd0,
    KIND_LOAD = 2'd1,
    KIND_MDU  = 2'd2,
    KIND_RSVD = 2'd3
  } kind_e;

  // fwd_sel value meaning "take the operand from the register file"
  localparam int unsigned FWD_RF = 0;

  // Slot rd field is sized for the widest supported register address; narrower
  // addresses are zero-extended on entry and on compare.
  localparam int unsigned RD_W = 8;

  typedef struct packed {
    logic            valid;
    logic            wen;
    logic [RD_W-1:0] rd;
    kind_e           kind;
  } slot_t;

  // A slot can only supply a value if it is live, writes, and does not target r0.
  function automatic logic slotWrites(slot_t s);
    return s.valid && s.wen && (s.rd != '0);
  endfunction

endpackage

// File: rtl/fwd_scoreboard_if.sv
// ID-stage <-> forwarding unit bundle. master = ID side, slave = scoreboard.
interface fwd_scoreboard_if #(
  parameter int unsigned NRP  = 2,
  parameter int unsigned NSTG = 3,
  parameter int unsigned AW   = 5,
  parameter int unsigned SW   = $clog2(NSTG + 2)
);
  logic              issue_valid;
  logic              issue_wen;
  logic [AW-1:0]     issue_rd;
  logic [1:0]        issue_kind;
  logic [NRP*AW-1:0] rd_addr;
  logic [NRP-1:0]    rd_used;
  logic              flush;
  logic [NRP*SW-1:0] fwd_sel;
  logic              stall;
  logic              mdu_busy;
  logic              mdu_done;

  modport master (
    output issue_valid, issue_wen, issue_rd, issue_kind, rd_addr, rd_used, flush,
    input  fwd_sel, stall, mdu_busy, mdu_done
  );

  modport slave (
    input  issue_valid, issue_wen, issue_rd, issue_kind, rd_addr, rd_used, flush,
    output fwd_sel, stall, mdu_busy, mdu_done
  );
endinterface

// File: rtl/mdu_tracker.sv
// Tracks the single in-flight multiply/divide op: occupancy counter and
// destination register. done marks the cycle the result can be bypassed.
module mdu_tracker #(
  parameter int unsigned AW      = 5,
  parameter int unsigned MDU_LAT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] startRd,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] pendRd
);
  localparam int unsigned CW = $clog2(MDU_LAT + 1);

  logic [CW-1:0] cnt;

  // Load on issue (also in the done cycle), otherwise count down to idle
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      pendRd <= '0;
    end else if (start) begin
      cnt    <= CW'(MDU_LAT);
      pendRd <= startRd;
    end else if (cnt != '0) begin
      cnt    <= cnt - CW'(1);
    end
  end

  assign busy = (cnt != '0);
  assign done = (cnt == CW'(1));

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding / hazard unit: shifts a per-stage scoreboard, picks the youngest
// producer per read port, and raises a single decode stall.
module fwd_scoreboard
  import pipe_pkg::*;
#(
  parameter int unsigned NRP     = 2,
  parameter int unsigned NSTG    = 3,
  parameter int unsigned AW      = 5,
  parameter int unsigned MDU_LAT = 4,
  parameter int unsigned SW      = $clog2(NSTG + 2)
) (
  input logic            clk,
  input logic            reset,
  fwd_scoreboard_if.slave bus
);

  slot_t          slots [NSTG];
  slot_t          newSlot;
  kind_e          issueKind;
  logic [AW-1:0]  mduRd;
  logic           mduBusy;
  logic           mduDone;
  logic           mduStart;
  logic [NRP-1:0] portHit;
  logic [NRP-1:0] loadUse;
  logic [NRP-1:0] mduHaz;
  logic           mduSlotHaz;
  logic           stallInt;
  logic           accept;

  // Reserved kind behaves as ALU
  always_comb begin
    issueKind = kind_e'(bus.issue_kind);
    if (issueKind == KIND_RSVD) issueKind = KIND_ALU;
  end

  // Per-port producer search and MDU result bypass
  always_comb begin
    bus.fwd_sel = '0;
    portHit     = '0;
    loadUse     = '0;
    mduHaz      = '0;
    for (int unsigned p = 0; p < NRP; p++) begin
      bus.fwd_sel[p*SW +: SW] = SW'(FWD_RF);
      if (bus.rd_used[p] && (bus.rd_addr[p*AW +: AW] != '0)) begin
        // Oldest to youngest so the youngest match is the one left standing
        for (int unsigned i = NSTG; i > 0; i--) begin
          if (slotWrites(slots[i-1]) && (slots[i-1].rd == RD_W'(bus.rd_addr[p*AW +: AW]))) begin
            portHit[p]              = 1'b1;
            bus.fwd_sel[p*SW +: SW] = SW'(i);
            loadUse[p]              = (i == 1) && (slots[i-1].kind == KIND_LOAD);
          end
        end
        if (!portHit[p] && mduBusy && (mduRd == bus.rd_addr[p*AW +: AW])) begin
          if (mduDone) bus.fwd_sel[p*SW +: SW] = SW'(NSTG + 1);
          else         mduHaz[p] = 1'b1;
        end
      end
    end
  end

  // Decode stall OR-tree and acceptance into slot 0
  always_comb begin
    mduSlotHaz = 1'b0;
    for (int unsigned i = 0; i < NSTG; i++) begin
      if (slots[i].valid && slots[i].wen && (slots[i].rd == RD_W'(bus.issue_rd)))
        mduSlotHaz = 1'b1;
    end
    stallInt = bus.issue_valid && !bus.flush &&
               ((|loadUse) || (|mduHaz) ||
                ((issueKind == KIND_MDU) && mduBusy && !mduDone) ||
                ((issueKind == KIND_MDU) && mduSlotHaz) ||
                (bus.issue_wen && mduBusy && (mduRd == bus.issue_rd) && !mduDone));
    accept   = bus.issue_valid && !stallInt && !bus.flush;
    mduStart = accept && (issueKind == KIND_MDU);

    newSlot       = '0;
    newSlot.valid = accept;
    newSlot.wen   = accept && bus.issue_wen && (issueKind != KIND_MDU);
    newSlot.rd    = RD_W'(bus.issue_rd);
    newSlot.kind  = issueKind;
    if (!accept) newSlot = '0;
  end

  assign bus.stall    = stallInt;
  assign bus.mdu_busy = mduBusy;
  assign bus.mdu_done = mduDone;

  // Scoreboard shift: slot 0 takes the ID instruction or a bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NSTG; i++) slots[i] <= '0;
    end else begin
      slots[0] <= newSlot;
      for (int unsigned i = 1; i < NSTG; i++) slots[i] <= slots[i-1];
    end
  end

  mdu_tracker #(
    .AW      (AW),
    .MDU_LAT (MDU_LAT)
  ) uMdu (
    .clk     (clk),
    .reset   (reset),
    .start   (mduStart),
    .startRd (bus.issue_rd),
    .busy    (mduBusy),
    .done    (mduDone),
    .pendRd  (mduRd)
  );

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: directed vector table, reset corner sequences,
// then random traffic against a timestamp-based reference model.
module tb_fwd_scoreboard;
  localparam int NRP = 2, NSTG = 3, AW = 5, MDU_LAT = 4, SW = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fwd_scoreboard_if #(.NRP(NRP), .NSTG(NSTG), .AW(AW), .SW(SW)) bus ();

  fwd_scoreboard #(.NRP(NRP), .NSTG(NSTG), .AW(AW), .MDU_LAT(MDU_LAT), .SW(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Accepted instructions are logged with the cycle they left ID; their age
  // alone decides which stage they occupy now.
  typedef struct { int c; bit wen; int rd; int kind; } ent_t;
  ent_t hist[$];
  int   n = 0;
  bit   mduOn = 0;
  int   mduC = 0;
  int   mduRd = 0;
  int   expSel [NRP];
  bit   expStall, expBusy, expDone, expAccept;

  task automatic modelEval();
    bit haz;
    int k, ph;
    haz = 0;
    ph = n - mduC;
    expBusy = mduOn && ph >= 1 && ph <= MDU_LAT;
    expDone = mduOn && ph == MDU_LAT;
    for (int p = 0; p < NRP; p++) begin
      int a, best, bestKind;
      a = int'(bus.rd_addr[p*AW +: AW]);
      expSel[p] = 0;
      best = 0; bestKind = 0;
      if (bus.rd_used[p] && a != 0) begin
        foreach (hist[j]) begin
          int age;
          age = n - hist[j].c;
          if (age >= 1 && age <= NSTG && hist[j].wen && hist[j].rd == a)
            if (best == 0 || age < best) begin best = age; bestKind = hist[j].kind; end
        end
        if (best != 0) begin
          expSel[p] = best;
          if (bestKind == 1 && best == 1) haz = 1;
        end else if (expBusy && mduRd == a) begin
          if (expDone) expSel[p] = NSTG + 1;
          else haz = 1;
        end
      end
    end
    k = int'(bus.issue_kind);
    if (k == 3) k = 0;
    if (k == 2 && expBusy && !expDone) haz = 1;
    if (k == 2)
      foreach (hist[j]) begin
        int age;
        age = n - hist[j].c;
        if (age >= 1 && age <= NSTG && hist[j].wen && hist[j].rd == int'(bus.issue_rd)) haz = 1;
      end
    if (bus.issue_wen && expBusy && !expDone && mduRd == int'(bus.issue_rd)) haz = 1;
    expStall  = bus.issue_valid && !bus.flush && haz;
    expAccept = bus.issue_valid && !bus.flush && !haz;
  endtask

  task automatic modelAdvance();
    int k;
    k = int'(bus.issue_kind);
    if (k == 3) k = 0;
    if (reset) begin
      hist.delete();
      mduOn = 0;
    end else if (expAccept) begin
      ent_t e;
      e.c = n; e.wen = bus.issue_wen && (k != 2); e.rd = int'(bus.issue_rd); e.kind = k;
      hist.push_back(e);
      if (k == 2) begin mduOn = 1; mduC = n; mduRd = int'(bus.issue_rd); end
    end
    n++;
    while (hist.size() > 0 && n - hist[0].c > NSTG) void'(hist.pop_front());
  endtask

  // ---------------- driving helpers ----------------
  task automatic drive(input bit v, input bit w, input int rd, input int k,
                       input int a0, input int a1, input bit [1:0] used, input bit fl);
    bus.issue_valid = v;
    bus.issue_wen   = w;
    bus.issue_rd    = AW'(rd);
    bus.issue_kind  = 2'(k);
    bus.rd_addr     = {AW'(a1), AW'(a0)};
    bus.rd_used     = used;
    bus.flush       = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 2'b00, 0);
  endtask

  // Inputs are driven at posedge+1; sampled at posedge+3; model steps at the edge.
  task automatic finishCycle();
    @(posedge clk);
    modelAdvance();
    #1;
  endtask

  typedef struct {
    bit v; bit w; int rd; int k; int a0; int a1; bit [1:0] used; bit fl;
    int s0; int s1; bit st; bit bz; bit dn;
  } vec_t;
  vec_t vt[$];

  task automatic addVec(input bit v, input bit w, input int rd, input int k,
                        input int a0, input int a1, input bit [1:0] used, input bit fl,
                        input int s0, input int s1, input bit st, input bit bz, input bit dn);
    vec_t x;
    x.v = v; x.w = w; x.rd = rd; x.k = k; x.a0 = a0; x.a1 = a1; x.used = used; x.fl = fl;
    x.s0 = s0; x.s1 = s1; x.st = st; x.bz = bz; x.dn = dn;
    vt.push_back(x);
  endtask

  initial begin
    // one row per cycle:  v w rd k  a0 a1 used fl | sel0 sel1 stall busy done
    addVec(0,0, 0,0, 0,0,2'b00,0, 0,0,0,0,0); // 0 idle
    addVec(1,1, 3,0, 0,0,2'b00,0, 0,0,0,0,0); // 1 ALU r3
    addVec(1,1, 4,0, 3,0,2'b01,0, 1,0,0,0,0); // 2 read r3 -> EX
    addVec(1,0, 0,0, 3,4,2'b11,0, 2,1,0,0,0); // 3 r3 in MEM, r4 in EX
    addVec(1,1, 5,1, 0,0,2'b00,0, 0,0,0,0,0); // 4 LOAD r5
    addVec(1,0, 0,0, 0,5,2'b10,0, 0,1,1,0,0); // 5 load-use stall
    addVec(1,0, 0,0, 0,5,2'b10,0, 0,2,0,0,0); // 6 released, MEM bypass
    addVec(1,1, 7,0, 0,0,2'b00,0, 0,0,0,0,0); // 7 ALU r7
    addVec(1,1, 7,0, 7,0,2'b01,0, 1,0,0,0,0); // 8 ALU r7 again
    addVec(1,0, 0,0, 7,0,2'b11,0, 1,0,0,0,0); // 9 youngest r7; r0 -> 0
    addVec(1,0, 0,0, 7,0,2'b01,0, 2,0,0,0,0); // 10 youngest r7 now MEM
    addVec(1,1, 5,1, 0,0,2'b00,0, 0,0,0,0,0); // 11 LOAD r5
    addVec(1,0, 0,0, 5,0,2'b01,1, 1,0,0,0,0); // 12 load-use but flushed
    addVec(0,0, 0,0, 5,0,2'b01,0, 2,0,0,0,0); // 13 flushed op was a bubble
    addVec(1,1, 9,2, 0,0,2'b00,0, 0,0,0,0,0); // 14 MDU r9
    addVec(1,0, 0,0, 9,0,2'b01,0, 0,0,1,1,0); // 15 wait on MDU
    addVec(1,0, 0,0, 9,0,2'b01,0, 0,0,1,1,0); // 16
    addVec(1,0, 0,0, 9,0,2'b01,0, 0,0,1,1,0); // 17
    addVec(1,0, 0,0, 9,0,2'b01,0, 4,0,0,1,1); // 18 done: MDU bypass
    addVec(0,0, 0,0, 0,0,2'b00,0, 0,0,0,0,0); // 19 idle after done
    addVec(1,1,10,2, 0,0,2'b00,0, 0,0,0,0,0); // 20 MDU r10
    addVec(1,1,11,2, 0,0,2'b00,0, 0,0,1,1,0); // 21 second MDU waits
    addVec(1,1,11,2, 0,0,2'b00,0, 0,0,1,1,0); // 22
    addVec(1,1,11,2, 0,0,2'b00,0, 0,0,1,1,0); // 23
    addVec(1,1,11,2, 0,0,2'b00,0, 0,0,0,1,1); // 24 accepted in done cycle
    addVec(0,0, 0,0, 0,0,2'b00,0, 0,0,0,1,0); // 25 busy stays high
    addVec(1,1,11,0, 0,0,2'b00,0, 0,0,1,1,0); // 26 WAW on r11
    addVec(1,1,11,0, 0,0,2'b00,0, 0,0,1,1,0); // 27
    addVec(1,1,11,0, 0,0,2'b00,0, 0,0,0,1,1); // 28 WAW clears at done
    addVec(0,0, 0,0, 0,0,2'b00,0, 0,0,0,0,0); // 29 idle

    idle();
    repeat (2) finishCycle();
    reset = 1'b0;

    // Reset state, with a read in ID that has nothing to match
    drive(1, 1, 6, 0, 3, 4, 2'b11, 0);
    #2;
    modelEval();
    check("rst_sel0", int'(bus.fwd_sel[0 +: SW]), 0);
    check("rst_sel1", int'(bus.fwd_sel[SW +: SW]), 0);
    check("rst_stall", int'(bus.stall), 0);
    check("rst_busy", int'(bus.mdu_busy), 0);
    check("rst_done", int'(bus.mdu_done), 0);
    idle();
    finishCycle();
    // flush the r6 producer out of the pipe before the table starts
    repeat (NSTG) begin #2; modelEval(); finishCycle(); end

    foreach (vt[r]) begin
      drive(vt[r].v, vt[r].w, vt[r].rd, vt[r].k, vt[r].a0, vt[r].a1, vt[r].used, vt[r].fl);
      #2;
      modelEval();
      check($sformatf("vec%0d_sel0", r), int'(bus.fwd_sel[0 +: SW]), vt[r].s0);
      check($sformatf("vec%0d_sel1", r), int'(bus.fwd_sel[SW +: SW]), vt[r].s1);
      check($sformatf("vec%0d_stall", r), int'(bus.stall), int'(vt[r].st));
      check($sformatf("vec%0d_busy", r), int'(bus.mdu_busy), int'(vt[r].bz));
      check($sformatf("vec%0d_done", r), int'(bus.mdu_done), int'(vt[r].dn));
      finishCycle();
    end

    // Reset in the middle of an MDU op: no done pulse afterwards
    drive(1, 1, 12, 2, 0, 0, 2'b00, 0);
    #2; modelEval(); finishCycle();
    idle();
    #2; modelEval();
    check("midmdu_busy", int'(bus.mdu_busy), 1);
    finishCycle();
    reset = 1'b1;
    #2; modelEval(); finishCycle();
    reset = 1'b0;
    drive(1, 0, 0, 0, 12, 0, 2'b01, 0);
    for (int c = 0; c < MDU_LAT + 1; c++) begin
      #2; modelEval();
      check($sformatf("postrst%0d_busy", c), int'(bus.mdu_busy), 0);
      check($sformatf("postrst%0d_done", c), int'(bus.mdu_done), 0);
      check($sformatf("postrst%0d_stall", c), int'(bus.stall), 0);
      finishCycle();
    end

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)), $urandom_range(0, 7) == 0);
      #2;
      modelEval();
      for (int p = 0; p < NRP; p++)
        check($sformatf("rnd%0d_sel%0d", c, p), int'(bus.fwd_sel[p*SW +: SW]), expSel[p]);
      check($sformatf("rnd%0d_stall", c), int'(bus.stall), int'(expStall));
      check($sformatf("rnd%0d_busy", c), int'(bus.mdu_busy), int'(expBusy));
      check($sformatf("rnd%0d_done", c), int'(bus.mdu_done), int'(expDone));
      finishCycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised forwarding and hazard unit for the MIPS pipeline. It generalises the two-source EX/MEM and MEM/WB bypass logic to NRP read ports and NSTG tracked post-decode stages, and adds a multi-cycle multiply/divide (MDU) result tracker. From a registered per-stage scoreboard it produces per-port bypass selects and a single decode stall. It sits beside the ID stage and drives the ID/EX operand muxes and the PC/IF_ID write enables.

## Interface
- NRP, 2: number of register read ports checked (rs, rt, …)
- NSTG, 3: tracked stages after ID; slot 0 = EX, 1 = MEM, 2 = WB
- AW, 5: register address width
- MDU_LAT, 4: MDU issue-to-result latency in cycles, minimum 2
- SW, $clog2(NSTG+2): select width (derived)

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- issue_valid  in  1  ID holds a valid instruction
- issue_wen  in  1  instruction writes a register
- issue_rd  in  AW  destination register
- issue_kind  in  2  0 = ALU, 1 = LOAD, 2 = MDU, 3 = reserved (treated as ALU)
- rd_addr  in  NRP*AW  source register per port; port p occupies bits [p*AW +: AW]
- rd_used  in  NRP  port p is actually read
- flush  in  1  squash the instruction in ID (branch/jump redirect)
- fwd_sel  out  NRP*SW  per port: 0 = register file, k = slot k−1 (1..NSTG), NSTG+1 = MDU result
- stall  out  1  hold PC and IF/ID; insert a bubble into EX
- mdu_busy  out  1  MDU operation in flight
- mdu_done  out  1  MDU result valid this cycle

## Operation
- Scoreboard: NSTG slots of {valid, wen, rd, kind}. Every cycle each slot shifts to the next; the last slot drops out.
- Slot 0 loading:
  - Loads the ID instruction when issue_valid && !stall && !flush.
  - Otherwise loads a bubble (valid = 0).
  - An MDU instruction enters with wen = 0. Its rd goes to the MDU tracker instead.
- Slot readiness:
  - ALU is ready in any slot.
  - LOAD is ready in slot ≥ 1 only.
  - A slot with wen = 0, rd = 0 or valid = 0 never matches.
- Per port p with rd_used[p] and rd_addr ≠ 0:
  - fwd_sel selects the lowest-index (youngest) matching slot.
  - If there is no slot match and the MDU tracker is pending on the same rd, select NSTG+1 only when mdu_done; otherwise the port hazards.
  - If nothing matches, fwd_sel = 0.
  - Ports with rd_used = 0 always give fwd_sel = 0.
- stall = issue_valid && !flush && any of:
  - a port's youngest match is a LOAD in slot 0 (load-use);
  - a port reads the pending MDU rd and mdu_done = 0;
  - issue_kind = MDU and (mdu_busy && !mdu_done);
  - issue_kind = MDU and any valid wen slot has the same rd;
  - issue_wen && issue_rd equals the pending MDU rd && !mdu_done (WAW).
- MDU tracker:
  - On MDU issue, loads cnt = MDU_LAT and latches rd.
  - Decrements each cycle.
  - mdu_done = (cnt == 1).
  - Clears to idle after the done cycle.
  - An MDU issue accepted in the done cycle reloads cnt immediately.
- flush has priority over stall; a flushed instruction never enters the scoreboard.

## Timing
- fwd_sel, stall and mdu_done are combinational from the registered state plus ID inputs, with no added latency.
- All state updates on the clk rising edge.
- An MDU op accepted at edge t asserts mdu_done throughout cycle t+MDU_LAT−1 after that edge, i.e. MDU_LAT cycles of occupancy. mdu_busy is high for those same cycles.
- A load-use stall lasts exactly 1 cycle.
- A dependent read of an MDU result stalls until the done cycle, then proceeds with fwd_sel = NSTG+1.
- On reset, all slots are invalid and cnt = 0. At the same time fwd_sel = 0, stall = 0, mdu_busy = 0 and mdu_done = 0.
- Reset mid-MDU discards the operation, with no done pulse.
- When stall and a shifting LOAD occur in the same cycle, the LOAD moves to slot 1 and the stall releases in the next cycle.

## Structure
- Shared package `pipe_pkg`:
  - kind encodings KIND_ALU/LOAD/MDU;
  - select constant FWD_RF = 0;
  - slot struct typedef.
- One sub-module, `mdu_tracker`, containing the counter, pending rd, busy and done. The top holds the slot shift register, match/priority logic and stall OR-tree.

## Test plan
- ALU r3 issued, next instruction reads r3 on port 0 → fwd_sel[0] = 1 and stall = 0. One cycle later the reader sees fwd_sel = 2.
- LOAD r5 issued, next instruction reads r5 on port 1 → stall = 1 for exactly 1 cycle, then fwd_sel[1] = 2.
- Two consecutive ALU writes to r7, then a read of r7 → fwd_sel = 1 (youngest), not 2. A read of r0 always gives 0.
- MDU to r9 with MDU_LAT = 4, then a read of r9 → stall for 3 cycles. In the done cycle fwd_sel = NSTG+1 = 4 and stall = 0.
- MDU busy, second MDU issued → stall until mdu_done. It is accepted in the done cycle and mdu_busy stays high continuously.
- LOAD-use hazard present with flush = 1 → stall = 0 and slot 0 is a bubble. Reset asserted mid-MDU → mdu_busy = 0 next cycle and no mdu_done.
